// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: master state encoding, default widths and timeout.
package wb_pkg;

  localparam int unsigned WB_AW              = 7;
  localparam int unsigned WB_DW              = 32;
  localparam int unsigned WB_LW              = 4;
  localparam int unsigned WB_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } wb_state_e;

endpackage

// File: rtl/wb_ack_timer.sv
// Ack watchdog: counts enabled cycles since the last clear, flags expiry at TIMEOUT.
module wb_ack_timer
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // An ack in the expiry cycle wins over the abort.
  assign expire_o = !clr_i && (cnt_q == W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Pipelined Wishbone initiator: single-beat writes and 1..2**LW-beat read bursts.
// Define WB_BURST_MASTER_TIMEOUT_EN to abort commands whose acks stop arriving.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int unsigned AW      = WB_AW,
  parameter int unsigned DW      = WB_DW,
  parameter int unsigned LW      = WB_LW,
  parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_addr,
  input  logic [LW-1:0] i_req_len,
  input  logic [DW-1:0] i_req_data,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_data,
  output logic          o_rsp_last,
  output logic          o_rsp_err,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic [DW-1:0] i_wb_data
);

  localparam int unsigned CW = LW + 1;

  wb_state_e     state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [LW-1:0] len_q, len_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] acked_q, acked_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_last_q, rsp_last_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic          ack, beat, expire;
  logic [CW-1:0] total;

  assign ack   = i_wb_ack && (state_q != IDLE);
  assign beat  = (state_q == ISSUE) && !i_wb_stall;
  assign total = {1'b0, len_q} + CW'(1);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  wb_ack_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   ((state_q == IDLE) || ack),
    .en_i    (state_q != IDLE),
    .expire_o(expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    len_d       = len_q;
    issued_d    = issued_q + CW'(beat);
    acked_d     = acked_q + CW'(ack);
    rsp_valid_d = ack;
    rsp_data_d  = (ack && !we_q) ? i_wb_data : '0;
    rsp_last_d  = ack && (acked_d == total);
    rsp_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          state_d  = ISSUE;
          we_d     = i_req_we;
          addr_d   = i_req_addr;
          data_d   = i_req_data;
          len_d    = i_req_we ? '0 : i_req_len;
          issued_d = '0;
          acked_d  = '0;
        end
      end
      ISSUE: begin
        // A combinational-ack slave may finish the burst while the last beat issues.
        if (beat && (issued_d == total)) begin
          state_d = (acked_d == total) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (acked_d == total) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (expire) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      rsp_last_d  = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      acked_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      acked_q     <= acked_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_wb_cyc    = (state_q != IDLE);
  assign o_wb_stb    = (state_q == ISSUE);
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q + AW'(issued_q);
  assign o_wb_data   = data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_last  = rsp_last_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master against a 128-word block-RAM slave model.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [6:0]  req_addr;
  logic [3:0]  req_len;
  logic [31:0] req_data;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic        wb_cyc, wb_stb, wb_we;
  logic [6:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        stall, ack_q, ack_en, load;
  logic [31:0] sdata_q;
  logic [31:0] mem    [128];
  logic [31:0] shadow [128];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_burst_master #(
    .AW(7), .DW(32), .LW(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_len(req_len), .i_req_data(req_data),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_last(rsp_last),
    .o_rsp_err(rsp_err), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .i_wb_stall(stall),
    .i_wb_ack(ack_q), .i_wb_data(sdata_q)
  );

  function automatic logic [31:0] rom_word(input int i);
    return 32'(32'hA0 + i - 16);
  endfunction

  // Slave: zero-wait, registered 1-cycle ack, data driven only with ack.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 128; i++) mem[i] <= rom_word(i);
    end else if (wb_cyc && wb_stb && !stall && wb_we) begin
      mem[wb_addr] <= wb_wdata;
    end
    if (reset) begin
      ack_q   <= 1'b0;
      sdata_q <= '0;
    end else begin
      ack_q   <= wb_cyc && wb_stb && !stall && ack_en;
      sdata_q <= (wb_cyc && wb_stb && !stall && ack_en && !wb_we) ? mem[wb_addr] : '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [3:0]  len;
    logic [31:0] wdata;
    int          stall_lo;
    int          stall_hi;
    int          exp_fall;
    logic [31:0] exp_d0;
  } vec_t;

  vec_t vecs[8];

  task automatic start_req(input logic we, input logic [6:0] a, input logic [3:0] l,
                           input logic [31:0] d);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l; req_data = d;
    stall = 1'b0;
    @(negedge clk);
    chk("ready_before_accept", req_ready, 1);
  endtask

  task automatic run_cmd(input vec_t v);
    int        fall   = -1;
    int        issued = 0;
    int        nrsp   = 0;
    int        total;
    bit        done   = 0;
    logic [6:0] ea;
    total = v.we ? 1 : int'(v.len) + 1;
    start_req(v.we, v.addr, v.len, v.wdata);
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      stall     = (c >= v.stall_lo) && (c <= v.stall_hi);
      @(negedge clk);
      if (wb_stb) begin
        ea = v.addr + 7'(issued);
        chk("stb_addr", wb_addr, ea);
        chk("stb_we", wb_we, v.we);
        if (v.we) chk("stb_wdata", wb_wdata, v.wdata);
        if (!stall) issued++;
      end
      if (rsp_valid) begin
        ea = v.addr + 7'(nrsp);
        chk("rsp_data", rsp_data, v.we ? 32'h0 : (nrsp == 0 ? v.exp_d0 : shadow[ea]));
        chk("rsp_last", rsp_last, (nrsp == total - 1));
        chk("rsp_err", rsp_err, 0);
        if (v.stall_hi < v.stall_lo) chk("rsp_cycle", c, 3 + nrsp);
        nrsp++;
      end
      if (fall < 0 && !wb_cyc) begin
        fall = c;
        chk("ready_at_cyc_fall", req_ready, 1);
      end
      if (fall >= 0 && c == fall + 1) done = 1;
    end
    stall = 1'b0;
    chk("cyc_fall_cycle", fall, v.exp_fall);
    chk("beats_issued", issued, total);
    chk("rsp_count", nrsp, total);
    if (v.we) shadow[v.addr] = v.wdata;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int fall;
    int nrsp;
    bit done;
    logic err_seen, last_seen;
    logic [31:0] err_data;

    for (int i = 0; i < 128; i++) shadow[i] = rom_word(i);
    //         we    addr   len   wdata         lo hi fall d0
    vecs[0] = '{1'b0, 7'h10, 4'd3, 32'h0,        0, -1, 6,  32'hA0};
    vecs[1] = '{1'b1, 7'h05, 4'hF, 32'hDEADBEEF, 0, -1, 3,  32'h0};
    vecs[2] = '{1'b0, 7'h05, 4'd0, 32'h0,        0, -1, 3,  32'hDEADBEEF};
    vecs[3] = '{1'b0, 7'h10, 4'd3, 32'h0,        2, 3,  8,  32'hA0};
    vecs[4] = '{1'b0, 7'h7F, 4'd1, 32'h0,        0, -1, 4,  32'h10F};
    vecs[5] = '{1'b0, 7'h00, 4'hF, 32'h0,        0, -1, 18, 32'h90};
    vecs[6] = '{1'b1, 7'h7F, 4'd2, 32'h12345678, 1, 2,  5,  32'h0};
    vecs[7] = '{1'b0, 7'h7E, 4'd2, 32'h0,        0, -1, 5,  32'h10E};

    reset = 1'b1; load = 1'b1; ack_en = 1'b1; stall = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_wb", {wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata}, 0);
    chk("reset_rsp", {rsp_valid, rsp_last, rsp_err, rsp_data}, 0);
    @(posedge clk); #1;
    reset = 1'b0; load = 1'b0;

    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

    // Reset while the master waits in DRAIN for an ack that never comes.
    ack_en = 1'b0;
    start_req(1'b0, 7'h20, 4'd0, 32'h0);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("drain_setup_stb", wb_stb, 1);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("drain_cyc_stb", {wb_cyc, wb_stb}, 2'b10);
    @(posedge clk); #1; reset = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    chk("post_reset_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
    chk("post_reset_ready", req_ready, 1);
    chk("post_reset_no_rsp", rsp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_no_rsp2", rsp_valid, 0);
    run_cmd(vecs[0]);

    // Slave never acks.
    ack_en = 1'b0;
    fall = -1; nrsp = 0; done = 0; err_seen = 0; last_seen = 0; err_data = '1;
    start_req(1'b0, 7'h30, 4'd0, 32'h0);
    for (int c = 1; c <= 100 && !done; c++) begin
      @(posedge clk); #1; req_valid = 1'b0;
      @(negedge clk);
      if (rsp_valid) begin
        nrsp++; err_seen = rsp_err; last_seen = rsp_last; err_data = rsp_data;
      end
      if (fall < 0 && !wb_cyc) fall = c;
      if (fall >= 0 && c == fall + 1) done = 1;
    end
`ifdef WB_BURST_MASTER_TIMEOUT_EN
    chk("tmo_cyc_fall", fall, 10);
    chk("tmo_rsp_count", nrsp, 1);
    chk("tmo_rsp_flags", {err_seen, last_seen}, 2'b11);
    chk("tmo_rsp_data", err_data, 0);
`else
    chk("hang_cyc_held", fall, -1);
    chk("hang_no_rsp", nrsp, 0);
    chk("hang_stb_low", wb_stb, 0);
`endif
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; ack_en = 1'b1;
    run_cmd(vecs[7]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Pipelined Wishbone initiator that drives the on-chip block-RAM slaves, including the boot ROM and data RAMs. It accepts one command at a time from a simple valid/ready request port. Each command is either a single-beat write or a read burst of 1–16 sequential words. Read data is streamed back on a response port. It sits between the CPU/loader logic and the Wishbone interconnect.

## Interface
- `AW`, default 7: Wishbone word-address width.
- `DW`, default 32: data width.
- `LW`, default 4: burst-length field width; a burst is `len+1` beats.
- `TIMEOUT`, default 64: idle cycles without an ack before abort. Used only with `WB_BURST_MASTER_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req_valid` in 1: command present.
- `o_req_ready` out 1: high only in IDLE.
- `i_req_we` in 1: 1 = write, 0 = read.
- `i_req_addr` in AW: start word address.
- `i_req_len` in LW: beats minus one. Ignored for writes (forced to 0).
- `i_req_data` in DW: write data.
- `o_rsp_valid` out 1: one-cycle pulse per completed beat.
- `o_rsp_data` out DW: read data; 0 for writes.
- `o_rsp_last` out 1: final beat of the command.
- `o_rsp_err` out 1: command aborted, qualified by `o_rsp_valid`.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1: Wishbone cycle, strobe and write enable.
- `o_wb_addr` out AW: Wishbone address.
- `o_wb_data` out DW: Wishbone write data.
- `i_wb_stall`, `i_wb_ack` in 1: slave stall and acknowledge.
- `i_wb_data` in DW: slave read data.

## Operation
Reset values:
- All outputs are 0, except `o_req_ready`, which is 1.
- State is IDLE; counters are 0.

States:
- IDLE → ISSUE on `i_req_valid && o_req_ready`. On that edge, latch `we`, `addr`, `data`, and `len` (forced to 0 when `we`=1), and clear `issued`, `acked`, and `tmo`.
- ISSUE:
  - `cyc`=`stb`=1; `o_wb_addr` = base + `issued` (AW-bit wrap-around is allowed).
  - A beat is issued on a cycle with `stb && !i_wb_stall`; `issued` increments.
  - When the final beat issues, go to DRAIN and drop `stb` on the next cycle.
  - While stalled, address, data and `we` are held stable.
- DRAIN: `cyc`=1, `stb`=0. Wait until `acked == len+1`, then go to IDLE and drop `cyc` on the same edge.

Acks:
- `i_wb_ack` is counted in both ISSUE and DRAIN.
- `i_wb_data` is sampled only on ack cycles. Slaves drive zeros otherwise, so the data is never sampled without an ack.
- Acks arriving while `cyc`=0 are ignored.
- An ack on the same cycle as the issue of a beat is legal: the issue and ack counters update independently.

Responses:
- One registered `o_rsp_valid` pulse per ack, with `o_rsp_data` = the captured `i_wb_data`.
- `o_rsp_last` is set on the pulse for the ack that makes `acked == len+1`.
- There is no response backpressure; the consumer must accept every pulse.

Reset:
- Reset mid-command drops `cyc`/`stb` immediately (registered), discards counters, and emits no response.

## Timing
Latency, with the request accepted at cycle 0:
- `o_wb_stb` rises at cycle 1.
- With zero stall and 1-cycle ack, beat *k* (0-based) issues at cycle 1+k and is acked at 2+k. Its response pulse is at 3+k.
- `cyc` falls, and `o_req_ready` rises, at cycle 3+len.
- The earliest next request is accepted at 3+len, so there is at most one command in flight.

Throughput: one beat per cycle when `i_wb_stall`=0.

## Configuration
`WB_BURST_MASTER_TIMEOUT_EN` defined:
- `tmo` counts cycles with `cyc`=1 and no ack; it clears on every ack.
- When `tmo` reaches `TIMEOUT`:
  - drop `cyc` and `stb` on the next cycle and go to IDLE;
  - emit one response with `o_rsp_valid`=1, `o_rsp_err`=1, `o_rsp_last`=1, `o_rsp_data`=0.
- Beats already acked have been reported normally.

Not defined:
- No counter is built and `o_rsp_err` is tied to 0.
- A missing ack hangs the master until reset.

## Structure
- Package `wb_pkg`: the state enum (IDLE, ISSUE, DRAIN), the `TIMEOUT` default, and the shared Wishbone width constants, reused by slave blocks.
- One sub-module, `wb_ack_timer`: the timeout counter with clear/expire. It is instantiated only under the macro.

## Test plan
- Read, len=3, addr 0x10, against a zero-stall 1-cycle-ack ROM holding 0xA0..0xA3 → stb at cycles 1–4 with addr 0x10–0x13; rsp pulses at 3–6 with data 0xA0..0xA3; last only at cycle 6; ready at 6.
- Write addr 0x05, data 0xDEADBEEF → one stb with `we`=1; a single rsp with last=1, data=0; a readback of 0x05 returns 0xDEADBEEF.
- Stall high for cycles 2–3 during a 4-beat read → addr holds at 0x11 for those cycles; 4 responses in order; no extra beats.
- Read len=1 at addr 0x7F → addresses 0x7F then 0x00 (wrap-around); data matches the ROM.
- Reset asserted in DRAIN → next cycle `cyc`=`stb`=0 and ready=1; no rsp pulse; a subsequent read completes correctly.
- With the macro and `TIMEOUT`=8, the slave never acks → `cyc` falls at cycle 10; one rsp with err=1 and last=1; without the macro, `cyc` stays high for 100 cycles.
